// File: rtl/button_press_classifier.sv
// Turns a debounced button level into one-cycle short, long and repeat events.
// Pulses and held are registered; counters stop at their terminal values.
module button_press_classifier #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int REPEAT_EN     = 1,
   parameter int CNT_W         = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic button_in,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] PRESSED   = 2'd1;
   localparam logic [1:0] LONG_HELD = 2'd2;

   localparam logic [CNT_W-1:0] HMAX = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] RMAX = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [1:0]       state, state_n;
   logic [CNT_W-1:0] hcnt, hcnt_n;
   logic [CNT_W-1:0] rcnt, rcnt_n;
   logic             short_n, long_n, rep_n;

   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      rcnt_n  = rcnt;
      short_n = 1'b0;
      long_n  = 1'b0;
      rep_n   = 1'b0;
      case (state)
         IDLE: begin
            if (button_in) begin
               state_n = PRESSED;
               hcnt_n  = ONE;
            end
         end
         PRESSED: begin
            if (!button_in) begin
               state_n = IDLE;
               short_n = 1'b1;
            end else if (hcnt == HMAX) begin
               state_n = LONG_HELD;
               long_n  = 1'b1;
               rcnt_n  = '0;
            end else begin
               hcnt_n = hcnt + ONE;
            end
         end
         LONG_HELD: begin
            // A long press ends silently on release.
            if (!button_in) begin
               state_n = IDLE;
            end else if (rcnt == RMAX) begin
               rcnt_n = '0;
               rep_n  = (REPEAT_EN != 0);
            end else begin
               rcnt_n = rcnt + ONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         hcnt         <= '0;
         rcnt         <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_pulse <= 1'b0;
         held         <= 1'b0;
      end else begin
         state        <= state_n;
         hcnt         <= hcnt_n;
         rcnt         <= rcnt_n;
         short_press  <= short_n;
         long_press   <= long_n;
         repeat_pulse <= rep_n;
         held         <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with a run-length reference model.
// Two instances differ only in REPEAT_EN; both see the same stimulus.
module tb_button_press_classifier;

   localparam int L = 8;
   localparam int R = 4;

   typedef struct packed {
      logic s;
      logic l;
      logic r;
      logic h;
      logic rn;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic button_in = 1'b0;
   logic short_press, long_press, repeat_pulse, held;
   logic short_nr, long_nr, repeat_nr, held_nr;

   int checks = 0;
   int errors = 0;
   int len = 0;
   int sc = 0, lc = 0, rc = 0, rnc = 0;
   int last_short = -100, gap = 0, cyc = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   button_press_classifier #(
      .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .button_in(button_in),
      .short_press(short_press), .long_press(long_press),
      .repeat_pulse(repeat_pulse), .held(held)
   );

   button_press_classifier #(
      .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(0), .CNT_W(4)
   ) dut_nr (
      .clk(clk), .reset(reset), .button_in(button_in),
      .short_press(short_nr), .long_press(long_nr),
      .repeat_pulse(repeat_nr), .held(held_nr)
   );

   task automatic check(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, want);
      end
   endtask

   task automatic step(input logic b, input logic r);
      exp_t e;
      exp_t p;
      logic [3:0] got, want;
      @(negedge clk);
      button_in = b;
      reset = r;
      e = '0;
      if (r) begin
         len = 0;
      end else if (b) begin
         len++;
         e.h = 1'b1;
         e.l = (len == L);
         e.r = (len > L) && ((len - L) % R == 0);
      end else begin
         e.s = (len >= 1) && (len < L);
         len = 0;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      p = q.pop_front();
      got  = {short_press, long_press, repeat_pulse, held};
      want = {p.s, p.l, p.r, p.h};
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL cyc%0d outs got %b exp %b", cyc, got, want);
      end
      got  = {short_nr, long_nr, repeat_nr, held_nr};
      want = {p.s, p.l, 1'b0, p.h};
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL cyc%0d outs_nr got %b exp %b", cyc, got, want);
      end
      if (short_press === 1'b1) begin
         sc++;
         gap = cyc - last_short;
         last_short = cyc;
      end
      if (long_press === 1'b1) lc++;
      if (repeat_pulse === 1'b1) rc++;
      if (repeat_nr === 1'b1) rnc++;
   endtask

   task automatic clr();
      sc = 0;
      lc = 0;
      rc = 0;
      rnc = 0;
   endtask

   task automatic run(input logic b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      step(1'b0, 1'b1);

      // reset held with button high, then press counts from release
      clr();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      run(1'b1, L);
      run(1'b0, 2);
      check("rst_long", lc, 1);
      check("rst_short", sc, 0);

      // short press of 3
      clr();
      run(1'b1, 3);
      run(1'b0, 2);
      check("short3_cnt", sc, 1);
      check("short3_long", lc, 0);

      // boundary 7 vs 8
      clr();
      run(1'b1, L - 1);
      run(1'b0, 2);
      check("b7_short", sc, 1);
      check("b7_long", lc, 0);
      clr();
      run(1'b1, L);
      run(1'b0, 2);
      check("b8_long", lc, 1);
      check("b8_short", sc, 0);

      // long hold with repeats
      clr();
      run(1'b1, 20);
      run(1'b0, 2);
      check("rep_long", lc, 1);
      check("rep_cnt", rc, 3);
      check("rep_nr_cnt", rnc, 0);
      check("rep_short", sc, 0);

      // back-to-back short presses
      clr();
      run(1'b1, 2);
      run(1'b0, 1);
      run(1'b1, 2);
      run(1'b0, 2);
      check("b2b_cnt", sc, 2);
      check("b2b_gap", gap, 3);

      // reset in the middle of a press
      clr();
      run(1'b1, 6);
      step(1'b1, 1'b1);
      run(1'b1, L);
      run(1'b0, 2);
      check("mid_short", sc, 0);
      check("mid_long", lc, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Classifies the clean, debounced button level into single-cycle user events: short press, long press and auto-repeat while held. It sits directly downstream of the button debouncer and upstream of the control FSM, which consumes only one-cycle pulses. The control logic never needs to time button presses itself.

## Interface
- `LONG_CYCLES`, default 50_000_000: consecutive high samples that make a press "long" (1 s at 50 MHz); legal range ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: additional high samples between repeat pulses once long; legal range ≥ 1.
- `REPEAT_EN`, default 1: 1 enables repeat pulses, 0 suppresses them.
- `CNT_W`, default 26: counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `button_in`, in, 1: debounced button level, synchronous to `clk`, 1 = pressed.
- `short_press`, out, 1: one-cycle pulse on release of a press shorter than `LONG_CYCLES`.
- `long_press`, out, 1: one-cycle pulse when a press reaches `LONG_CYCLES`.
- `repeat_pulse`, out, 1: one-cycle pulse every `REPEAT_CYCLES` while held after `long_press`.
- `held`, out, 1: level, 1 while the FSM is in PRESSED or LONG_HELD.

## Operation
- The FSM has three states: IDLE, PRESSED and LONG_HELD. A hold counter `hcnt` and a repeat counter `rcnt` are each `CNT_W` bits wide.
- IDLE:
  - If `button_in`=1, go to PRESSED and set `hcnt` to 1.
  - Otherwise stay in IDLE.
- PRESSED:
  - If `button_in`=0, pulse `short_press` and go to IDLE.
  - Else if `hcnt` = `LONG_CYCLES`-1, pulse `long_press`, go to LONG_HELD and clear `rcnt` to 0.
  - Else increment `hcnt`.
- LONG_HELD:
  - If `button_in`=0, go to IDLE with no pulse. A long press never also yields `short_press`.
  - Else if `rcnt` = `REPEAT_CYCLES`-1, clear `rcnt` and pulse `repeat_pulse`, gated by `REPEAT_EN`.
  - Else increment `rcnt`.
- All pulse outputs are registered. They are high for exactly one cycle and never overlap each other.
- Counters saturate by construction: `hcnt` never exceeds `LONG_CYCLES`-1 and `rcnt` never exceeds `REPEAT_CYCLES`-1, so no wrap-around occurs.
- `held` is registered and equals (next state ≠ IDLE).

## Timing
- Reset: the state goes to IDLE, `hcnt`=`rcnt`=0, and `short_press`, `long_press`, `repeat_pulse` and `held` are all 0 in the cycle after `reset` is sampled high.
- `reset` has priority over `button_in`.
- Reset mid-press: the press is discarded with no pulse. If `button_in` is still 1 after reset is released, a new press starts from the first post-reset sample.
- Cycle numbering: cycle 1 is the first edge with `button_in`=1 sampled in IDLE. `held`=1 after edge 1.
- `long_press`: high in the cycle after edge `LONG_CYCLES`, provided all samples 1..`LONG_CYCLES` were 1.
- `short_press`: if the first 0 is sampled at edge k with k ≤ `LONG_CYCLES`, the pulse is high after edge k. A press of 1 cycle is legal and yields `short_press`.
- `repeat_pulse`: the first pulse is high after edge `LONG_CYCLES` + `REPEAT_CYCLES`, then every `REPEAT_CYCLES` cycles.
- `held` falls after the edge that samples the release.
- Back-to-back presses: a 0 sample returns the FSM to IDLE, and a 1 on the next edge starts a new press. Minimum spacing is one low cycle.

## Test plan
All scenarios use `LONG_CYCLES`=8, `REPEAT_CYCLES`=4 and `CNT_W`=4.
- Reset: assert `reset` for 2 cycles with `button_in`=1 → all outputs 0 during reset. The first press counts from the first post-reset edge, and `long_press` fires 8 cycles later.
- Short press: `button_in` high for 3 cycles, then low → exactly one `short_press`, high after the 4th edge; `held` is high for 3 cycles; no other pulses.
- Boundary: hold for 7 cycles → `short_press`. Hold for 8 cycles then release → `long_press` after edge 8, and no `short_press` on release.
- Repeat: hold for 20 cycles → `long_press` after edge 8, then `repeat_pulse` after edges 12, 16 and 20, with no `short_press`. Repeat the run with `REPEAT_EN`=0 → zero `repeat_pulse`.
- Back-to-back: press 2 cycles, low 1 cycle, press 2 cycles → two `short_press` pulses, 3 cycles apart.
- Mid-press reset: hold for 6 cycles, assert `reset` for 1 cycle, keep `button_in`=1 for 8 more cycles → no `short_press`, and `long_press` fires 8 cycles after reset is released.
